general_purpose_register_scoreboard: RTL
========================================

Name: general_purpose_register_scoreboard

Overview:
Parametrised register file for the pipeline datapath: DEPTH x DATA_WIDTH storage, two combinational read ports and one clocked write port. It integrates a per-register busy scoreboard that tracks in-flight writes, so hazard detection in decode reads a register's value and its pending state from one block. Register 0 can be hardwired to zero. The scoreboard supports a pipeline flush.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
HARDWIRE_ZERO, 1, 1: register 0 always reads 0, is never written and is never marked busy; 0: register 0 is an ordinary register

Ports:
system_clock  input  1  clock; all state updates on the rising edge
system_reset_n  input  1  asynchronous, active-low reset
write_enable  input  1  commit write_data to write_address at the next rising edge
write_address  input  ADDR_WIDTH  writeback destination
write_data  input  DATA_WIDTH  writeback value
read_address_1  input  ADDR_WIDTH  read port 1 address
read_address_2  input  ADDR_WIDTH  read port 2 address
read_data_1  output  DATA_WIDTH  read port 1 value, combinational
read_data_2  output  DATA_WIDTH  read port 2 value, combinational
issue_enable  input  1  an instruction writing issue_address has issued; mark it busy
issue_address  input  ADDR_WIDTH  destination of the issuing instruction
flush  input  1  clear all busy bits at the next edge
read_busy_1  output  1  busy bit of read_address_1, combinational
read_busy_2  output  1  busy bit of read_address_2, combinational
outstanding_count  output  ADDR_WIDTH+1  number of set busy bits, registered

Behaviour:
- Reset, asynchronous, while system_reset_n=0:
  - all registers clear to 0
  - all busy bits clear to 0
  - outstanding_count = 0
  - read_data_* = 0 and read_busy_* = 0
  - any write, issue or flush in that cycle is discarded
- Write:
  - when write_enable=1, registers[write_address] <= write_data at the rising edge; one-cycle latency
  - with HARDWIRE_ZERO=1, a write to address 0 is ignored
- Read:
  - purely combinational from the array and busy bits
  - with HARDWIRE_ZERO=1, address 0 returns 0 and busy 0
- Scoreboard, per address a, at each rising edge, priority high to low:
  1. flush=1: busy[a] <= 0 for all a; same-edge issue and clear are ignored, but the same-edge data write still commits.
  2. issue_enable=1 and issue_address=a: busy[a] <= 1. Issue wins over a same-edge clear to the same address, because a newer producer supersedes the one writing back.
  3. write_enable=1 and write_address=a: busy[a] <= 0.
  4. Otherwise busy[a] holds.
- Issue and address 0: issue to address 0 with HARDWIRE_ZERO=1 is ignored.
- Re-issue: issue to an already-busy register keeps it busy; no count change.
- Clear of an idle register: the clear has no effect; no count change.
- outstanding_count:
  - updated at the same edge as the busy bits; equals the popcount of the next busy vector
  - maintained incrementally: +1 on an effective set of a clear bit, −1 on an effective clear of a set bit, 0 on flush
  - never wraps, since its maximum is DEPTH

Optional Feature:
GPR_WRITE_BYPASS_EN
- Defined:
  - If write_enable=1 and read_address_n equals write_address (and is not a hardwired zero), read_data_n returns write_data in the same cycle.
  - In the same condition, read_busy_n returns 0, unless issue_enable=1 targets the same address in that cycle, in which case it returns 1.
- Undefined:
  - Reads return the stored value and the stored busy bit.
  - The written value becomes visible in the cycle after the edge.

Test Plan:
- Reset: drive system_reset_n=0 mid-cycle after writing 0xDEADBEEF to r5 -> read_data_1 at r5 = 0 immediately (asynchronous); outstanding_count = 0.
- Write then read: write r7 = 0x12345678 -> next cycle read_data_2 = 0x12345678. Write r0 = 0xFFFFFFFF -> r0 reads 0 (HARDWIRE_ZERO=1).
- Scoreboard sequence:
  - issue r3, then issue r4 -> read_busy_1 for r3 = 1 and outstanding_count = 2
  - write back r3 -> busy(r3) = 0 and count = 1
- Simultaneous same-edge issue and writeback to r9, r9 previously busy -> busy(r9) stays 1; data written; count unchanged.
- Flush: issue r1, r2, r3; then flush with a same-edge issue of r4 -> all busy = 0 and count = 0 at the next edge.
- Bypass: write r10 = 0xA5A5A5A5 while reading r10 -> with GPR_WRITE_BYPASS_EN, same-cycle read_data = 0xA5A5A5A5; without it, the old value this cycle and 0xA5A5A5A5 the next.

Source files
------------

// File: rtl/general_purpose_register_scoreboard_if.sv
// Register file / scoreboard bus: writeback, issue, flush and two read ports.
// master drives requests, slave is the register file.
interface general_purpose_register_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [ADDR_WIDTH-1:0] read_address_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  issue_enable;
    logic [ADDR_WIDTH-1:0] issue_address;
    logic                  flush;
    logic                  read_busy_1;
    logic                  read_busy_2;
    logic [ADDR_WIDTH:0]   outstanding_count;

    modport master (
        output write_enable,
        output write_address,
        output write_data,
        output read_address_1,
        output read_address_2,
        output issue_enable,
        output issue_address,
        output flush,
        input  read_data_1,
        input  read_data_2,
        input  read_busy_1,
        input  read_busy_2,
        input  outstanding_count
    );

    modport slave (
        input  write_enable,
        input  write_address,
        input  write_data,
        input  read_address_1,
        input  read_address_2,
        input  issue_enable,
        input  issue_address,
        input  flush,
        output read_data_1,
        output read_data_2,
        output read_busy_1,
        output read_busy_2,
        output outstanding_count
    );
endinterface

// File: rtl/general_purpose_register_scoreboard.sv
// Register file with per-register busy scoreboard and outstanding counter.
// Optional GPR_WRITE_BYPASS_EN forwards same-cycle writeback to the read ports.
module general_purpose_register_scoreboard #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter bit HARDWIRE_ZERO = 1'b1
) (
    input  logic system_clock,
    input  logic system_reset_n,
    general_purpose_register_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] registers [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_next;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;

    logic write_effective;
    logic issue_effective;
    logic clear_effective;
    logic count_increment;
    logic count_decrement;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] address);
        return HARDWIRE_ZERO && (address == '0);
    endfunction

    assign write_effective = bus.write_enable
                          && !is_zero_reg(bus.write_address);

    assign issue_effective = bus.issue_enable
                          && !bus.flush
                          && !is_zero_reg(bus.issue_address);

    assign clear_effective = write_effective && !bus.flush;

    // A same-edge issue to the writeback target keeps the bit set.
    assign count_increment = issue_effective
                          && !busy_q[bus.issue_address];

    assign count_decrement = clear_effective
                          && busy_q[bus.write_address]
                          && !(issue_effective
                               && bus.issue_address == bus.write_address);

    always_comb begin
        busy_next = busy_q;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (clear_effective) begin
                busy_next[bus.write_address] = 1'b0;
            end
            if (issue_effective) begin
                busy_next[bus.issue_address] = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count_q;
        if (bus.flush) begin
            count_next = '0;
        end else begin
            count_next = count_q
                       + CW'(count_increment)
                       - CW'(count_decrement);
        end
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (write_effective) begin
            registers[bus.write_address] <= bus.write_data;
        end
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_next;
            count_q <= count_next;
        end
    end

    logic [DATA_WIDTH-1:0] read_value_1;
    logic [DATA_WIDTH-1:0] read_value_2;
    logic                  read_pending_1;
    logic                  read_pending_2;

    always_comb begin
        read_value_1   = registers[bus.read_address_1];
        read_pending_1 = busy_q[bus.read_address_1];
`ifdef GPR_WRITE_BYPASS_EN
        if (write_effective && bus.read_address_1 == bus.write_address) begin
            read_value_1   = bus.write_data;
            read_pending_1 = bus.issue_enable
                          && bus.issue_address == bus.read_address_1;
        end
`endif
        if (is_zero_reg(bus.read_address_1)) begin
            read_value_1   = '0;
            read_pending_1 = 1'b0;
        end
    end

    always_comb begin
        read_value_2   = registers[bus.read_address_2];
        read_pending_2 = busy_q[bus.read_address_2];
`ifdef GPR_WRITE_BYPASS_EN
        if (write_effective && bus.read_address_2 == bus.write_address) begin
            read_value_2   = bus.write_data;
            read_pending_2 = bus.issue_enable
                          && bus.issue_address == bus.read_address_2;
        end
`endif
        if (is_zero_reg(bus.read_address_2)) begin
            read_value_2   = '0;
            read_pending_2 = 1'b0;
        end
    end

    // Gate the read ports so a bypassed write cannot leak out during reset.
    assign bus.read_data_1       = system_reset_n ? read_value_1 : '0;
    assign bus.read_data_2       = system_reset_n ? read_value_2 : '0;
    assign bus.read_busy_1       = system_reset_n && read_pending_1;
    assign bus.read_busy_2       = system_reset_n && read_pending_2;
    assign bus.outstanding_count = count_q;
endmodule
